// File: rtl/addsub_rr_scheduler.sv
// -----------------------------------------------------------------------------
// addsub_rr_scheduler
// Round-robin scheduler that shares one unsigned add/subtract unit (with zero
// and carry/borrow flags) among NUM_REQ requesters. A request is granted in
// IDLE, its operands are computed in a registered EXEC stage, and the result
// is held on a valid/ready response port until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   areset     asynchronous reset, active-high
//   req_valid  per-requester request
//   req_sub    per-requester op select (0: a+b, 1: a-b)
//   req_a      operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      operand B, same packing
//   req_ready  one-hot grant (combinational, IDLE only)
//   rsp_valid  response valid
//   rsp_ready  consumer accepts response
//   rsp_id     requester index that issued the op
//   rsp_out    result modulo 2^WIDTH
//   rsp_zero   1 iff rsp_out == 0
//   rsp_carry  add: carry out; sub: borrow (a < b)
//   busy       scheduler not idle
//   op_count   completed responses, wraps
// -----------------------------------------------------------------------------
module addsub_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_sub,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_out,
    output logic                     rsp_zero,
    output logic                     rsp_carry,
    output logic                     busy,
    output logic [CNT_W-1:0]         op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_out;
    logic               r_rsp_zero;
    logic               r_rsp_carry;
    logic               r_busy;
    logic [CNT_W-1:0]   r_op_count;

    logic               w_found;
    logic [ID_W-1:0]    w_win_id;
    int unsigned        w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic               w_sel_sub;
    logic [WIDTH:0]     w_res;

    // Round-robin pick: first valid requester after the last winner, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_idx    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = (32'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[ID_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_win_id = ID_W'(w_idx);
            end
        end
    end

    // Grant is only offered while idle.
    always_comb begin
        w_grant = '0;
        if (r_state == ST_IDLE && w_found) begin
            w_grant[w_win_id] = 1'b1;
        end
    end

    // Operand mux for the winner (constant slices keep the selects static).
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (ID_W'(j) == w_win_id) begin
                w_sel_a   = req_a[j*WIDTH +: WIDTH];
                w_sel_b   = req_b[j*WIDTH +: WIDTH];
                w_sel_sub = req_sub[j];
            end
        end
    end

    // One extra bit captures carry on add and borrow on subtract.
    always_comb begin
        if (r_sub) begin
            w_res = {1'b0, r_a} - {1'b0, r_b};
        end else begin
            w_res = {1'b0, r_a} + {1'b0, r_b};
        end
    end

    // Scheduler FSM with registered response outputs.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_out   <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_carry <= 1'b0;
            r_busy      <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_sub    <= w_sel_sub;
                        r_rr_ptr <= w_win_id;
                        r_busy   <= 1'b1;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_out   <= w_res[WIDTH-1:0];
                    r_rsp_zero  <= (w_res[WIDTH-1:0] == '0);
                    r_rsp_carry <= w_res[WIDTH];
                    r_rsp_id    <= r_rr_ptr;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_op_count  <= r_op_count + CNT_W'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_out   = r_rsp_out;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_carry = r_rsp_carry;
    assign busy      = r_busy;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_addsub_rr_scheduler
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a transaction-level reference model. A second instance
// with a 4-bit counter exercises op_count wrap-around.
// -----------------------------------------------------------------------------
module tb_addsub_rr_scheduler;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  req_valid;
    logic [3:0]  req_sub;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_ready;

    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_out;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        busy;
    logic [15:0] op_count;

    logic [3:0]  s_req_ready;
    logic        s_rsp_valid;
    logic [1:0]  s_rsp_id;
    logic [7:0]  s_rsp_out;
    logic        s_rsp_zero;
    logic        s_rsp_carry;
    logic        s_busy;
    logic [3:0]  s_op_count;

    always #5 clk = ~clk;

    addsub_rr_scheduler #(.NUM_REQ(4), .WIDTH(8), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .areset(areset), .req_valid(req_valid), .req_sub(req_sub),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .busy(busy), .op_count(op_count)
    );

    addsub_rr_scheduler #(.NUM_REQ(4), .WIDTH(8), .ID_W(2), .CNT_W(4)) dut_small (
        .clk(clk), .areset(areset), .req_valid(req_valid), .req_sub(req_sub),
        .req_a(req_a), .req_b(req_b), .req_ready(s_req_ready),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_out(s_rsp_out), .rsp_zero(s_rsp_zero), .rsp_carry(s_rsp_carry),
        .busy(s_busy), .op_count(s_op_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: transaction-level view of the scheduler.
    int          m_phase;   // 0 waiting for grant, 1 computing, 2 holding response
    int          m_last;    // last granted requester
    logic [7:0]  m_a, m_b;
    logic        m_sub;
    int          m_id;
    logic        e_valid;
    logic [1:0]  e_id;
    logic [7:0]  e_out;
    logic        e_zero, e_carry;
    logic [15:0] e_cnt;
    logic [3:0]  e_cnt4;
    int          gnt_q[$];
    logic [3:0]  g_obs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_last = 3; m_a = '0; m_b = '0; m_sub = 1'b0; m_id = 0;
        e_valid = 1'b0; e_id = '0; e_out = '0; e_zero = 1'b0; e_carry = 1'b0;
        e_cnt = '0; e_cnt4 = '0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'(e_valid));
        chk({pfx, "_rsp_id"},    32'(rsp_id),    32'(e_id));
        chk({pfx, "_rsp_out"},   32'(rsp_out),   32'(e_out));
        chk({pfx, "_rsp_zero"},  32'(rsp_zero),  32'(e_zero));
        chk({pfx, "_rsp_carry"}, 32'(rsp_carry), 32'(e_carry));
        chk({pfx, "_busy"},      32'(busy),      32'(m_phase != 0));
        chk({pfx, "_op_count"},  32'(op_count),  32'(e_cnt));
        chk({pfx, "_op_count4"}, 32'(s_op_count), 32'(e_cnt4));
    endtask

    // Asynchronous reset asserted mid-cycle, released after the next edge.
    task automatic do_reset();
        req_valid = '0;
        areset = 1'b1;
        #1;
        model_reset();
        check_outputs("rst");
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    // One clock of stimulus: drive, check the grant, advance the model, check outputs.
    task automatic cycle(input logic [3:0] v, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] b, input logic rr);
        int w;
        int r;
        logic [3:0] exp_gnt;
        req_valid = v; req_sub = s; req_a = a; req_b = b; rsp_ready = rr;
        #1;
        w = -1;
        exp_gnt = '0;
        if (m_phase == 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && v[(m_last + k) % 4]) w = (m_last + k) % 4;
            end
        end
        if (w >= 0) exp_gnt[w] = 1'b1;
        g_obs = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_gnt));
        chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (m_phase == 0) begin
            if (w >= 0) begin
                m_a = a[w*8 +: 8]; m_b = b[w*8 +: 8]; m_sub = s[w]; m_id = w;
                m_last = w; m_phase = 1;
                gnt_q.push_back(w);
            end
        end else if (m_phase == 1) begin
            r = m_sub ? (int'(m_a) - int'(m_b)) : (int'(m_a) + int'(m_b));
            e_out   = 8'(r);
            e_zero  = (e_out == 8'd0);
            e_carry = m_sub ? (m_a < m_b) : (r > 255);
            e_id    = 2'(m_id);
            e_valid = 1'b1;
            m_phase = 2;
        end else if (rr) begin
            e_valid = 1'b0;
            e_cnt   = e_cnt + 16'd1;
            e_cnt4  = e_cnt4 + 4'd1;
            m_phase = 0;
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    int exp_order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        areset = 1'b0; req_valid = '0; req_sub = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #2;
        do_reset();

        // Reset during EXEC discards the op; arbitration restarts at req0.
        cycle(4'b0001, 4'b0000, 32'h0000_0005, 32'h0000_0003, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, '0, '0, 1'b1);
        chk("t1_no_rsp", 32'(rsp_valid), 32'd0);
        cycle(4'b1111, 4'b0000, 32'h0101_0101, 32'h0101_0101, 1'b0);
        chk("t1_regrant_req0", 32'(g_obs), 32'h1);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b0);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b1);

        // Single add with carry; response two cycles after acceptance.
        cycle(4'b0100, 4'b0000, 32'h00C8_0000, 32'h0064_0000, 1'b0);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b0);
        chk("t2_valid", 32'(rsp_valid), 32'd1);
        chk("t2_id",    32'(rsp_id),    32'd2);
        chk("t2_out",   32'(rsp_out),   32'd44);
        chk("t2_carry", 32'(rsp_carry), 32'd1);
        chk("t2_zero",  32'(rsp_zero),  32'd0);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b1);

        // Subtract boundaries and add overflow to zero.
        cycle(4'b0010, 4'b0010, 32'h0000_1000, 32'h0000_1000, 1'b0);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b0);
        chk("t3_eq_out",   32'(rsp_out),   32'd0);
        chk("t3_eq_zero",  32'(rsp_zero),  32'd1);
        chk("t3_eq_carry", 32'(rsp_carry), 32'd0);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b1);
        cycle(4'b1000, 4'b1000, 32'h0000_0000, 32'h0100_0000, 1'b0);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b0);
        chk("t3_brw_out",   32'(rsp_out),   32'hFF);
        chk("t3_brw_zero",  32'(rsp_zero),  32'd0);
        chk("t3_brw_carry", 32'(rsp_carry), 32'd1);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b1);
        cycle(4'b0001, 4'b0000, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b0);
        chk("t3_ovf_out",   32'(rsp_out),   32'd0);
        chk("t3_ovf_zero",  32'(rsp_zero),  32'd1);
        chk("t3_ovf_carry", 32'(rsp_carry), 32'd1);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b1);

        // All requesters held valid: strict rotation from req0.
        do_reset();
        gnt_q.delete();
        for (int i = 0; i < 18; i++) cycle(4'b1111, 4'b0101, 32'h1122_3344, 32'h0102_0304, 1'b1);
        chk("t4_grant_count", 32'(gnt_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < gnt_q.size(); i++) chk("t4_grant_order", 32'(gnt_q[i]), 32'(exp_order[i]));

        // Response back-pressure: outputs held, no grants, counter frozen.
        cycle(4'b0010, 4'b0000, 32'h0000_3000, 32'h0000_0700, 1'b0);
        cycle(4'b1111, 4'b0000, '0, '0, 1'b0);
        chk("t5_valid", 32'(rsp_valid), 32'd1);
        chk("t5_out", 32'(rsp_out), 32'h37);
        for (int i = 0; i < 10; i++) cycle(4'b1111, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b0);
        chk("t5_hold_out", 32'(rsp_out), 32'h37);
        chk("t5_hold_cnt", 32'(op_count), 32'd6);
        cycle(4'b0000, 4'b0000, '0, '0, 1'b1);
        chk("t5_release_cnt", 32'(op_count), 32'd7);
        chk("t5_idle", 32'(busy), 32'd0);

        // Random traffic; the 4-bit counter instance wraps repeatedly.
        for (int i = 0; i < 800; i++) begin
            cycle(4'($urandom), 4'($urandom), $urandom, $urandom, ($urandom_range(0, 3) != 0));
        end
        chk("t6_total_ops", 32'(e_cnt > 16'd32), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
